// File: rtl/hwpe_ctrl_seq_div.sv
// Unsigned restoring divider, one quotient bit per cycle; operands captured at start.
// Latency: accept in cycle 0 -> valid_o in cycle NW+1 (cycle 1 for divisor zero with HWPE_CTRL_SEQ_DIV_ZERO_FAST_EN).
// Backpressure: ready_o low while BUSY; start_i is ignored then. Results stay until the next start or clear.
module hwpe_ctrl_seq_div #(
    parameter int unsigned NW = 16,
    parameter int unsigned DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          start_i,
    input  logic [NW-1:0] dividend_i,
    input  logic [DW-1:0] divisor_i,
    output logic          valid_o,
    output logic          ready_o,
    output logic [NW-1:0] quot_o,
    output logic [DW-1:0] rem_o,
    output logic          dz_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NW-1:0] q_q, q_d;
    logic [DW-1:0] pr_q, pr_d;
    logic [DW-1:0] div_q, div_d;
    logic          dz_q, dz_d;

    logic [DW:0]   pr_sh;
    logic [DW-1:0] pr_sub;
    logic          ge;

`ifdef HWPE_CTRL_SEQ_DIV_ZERO_FAST_EN
    localparam int unsigned MW = (NW > DW) ? NW : DW;
    logic [MW-1:0] dvd_wide;
    logic [DW-1:0] dvd_rem;

    // Dividend truncated or zero-extended to remainder width for the zero-divisor shortcut.
    always_comb begin
        dvd_wide = MW'(dividend_i);
        dvd_rem  = dvd_wide[DW-1:0];
    end
`endif

    // One restoring step: shift in next dividend bit, trial-subtract the divisor.
    // The true difference is below 2^DW whenever ge is set, so a DW-bit subtract suffices.
    always_comb begin
        pr_sh  = {pr_q, q_q[NW-1]};
        ge     = (pr_sh >= {1'b0, div_q});
        pr_sub = pr_sh[DW-1:0] - div_q;
    end

    // Next-state and datapath update for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        pr_d    = pr_q;
        div_d   = div_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = BUSY;
                    div_d   = divisor_i;
                    q_d     = dividend_i;
                    pr_d    = '0;
                    cnt_d   = '0;
                    dz_d    = (divisor_i == '0);
`ifdef HWPE_CTRL_SEQ_DIV_ZERO_FAST_EN
                    // Same values the full iteration would produce for a zero divisor.
                    if (divisor_i == '0) begin
                        state_d = DONE;
                        q_d     = '1;
                        pr_d    = dvd_rem;
                    end
`endif
                end
            end
            BUSY: begin
                pr_d = ge ? pr_sub : pr_sh[DW-1:0];
                q_d  = (q_q << 1) | NW'(ge);
                if (cnt_q == CW'(NW - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset and soft clear drop any in-flight result.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            pr_q    <= '0;
            div_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            pr_q    <= pr_d;
            div_q   <= div_d;
            dz_q    <= dz_d;
        end
    end

    assign valid_o = (state_q == DONE);
    assign ready_o = (state_q != BUSY);
    assign quot_o  = q_q;
    assign rem_o   = pr_q;
    assign dz_o    = dz_q;

endmodule

// File: tb/tb_hwpe_ctrl_seq_div.sv
// Directed and random checks of hwpe_ctrl_seq_div at NW=DW=8 and NW=16/DW=5.
// Latency: checks exact cycle of valid_o relative to accept.
// Backpressure: exercises start_i while BUSY and in the DONE cycle.
module tb_hwpe_ctrl_seq_div;

`ifdef HWPE_CTRL_SEQ_DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clear_i;
    logic        start_i;
    logic [7:0]  dividend_i;
    logic [7:0]  divisor_i;
    logic        valid_o, ready_o, dz_o;
    logic [7:0]  quot_o, rem_o;

    logic        w_clear_i;
    logic        w_start_i;
    logic [15:0] w_dividend_i;
    logic [4:0]  w_divisor_i;
    logic        w_valid_o, w_ready_o, w_dz_o;
    logic [15:0] w_quot_o;
    logic [4:0]  w_rem_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    hwpe_ctrl_seq_div #(.NW(8), .DW(8)) u_dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (clear_i),
        .start_i    (start_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .valid_o    (valid_o),
        .ready_o    (ready_o),
        .quot_o     (quot_o),
        .rem_o      (rem_o),
        .dz_o       (dz_o)
    );

    hwpe_ctrl_seq_div #(.NW(16), .DW(5)) u_dut_w (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (w_clear_i),
        .start_i    (w_start_i),
        .dividend_i (w_dividend_i),
        .divisor_i  (w_divisor_i),
        .valid_o    (w_valid_o),
        .ready_o    (w_ready_o),
        .quot_o     (w_quot_o),
        .rem_o      (w_rem_o),
        .dz_o       (w_dz_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Start a/b in the current cycle, scramble operands while busy, then check results.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int lat,
                         input logic [7:0] eq, input logic [7:0] er, input logic edz,
                         input string tag);
        int n;
        start_i    = 1'b1;
        dividend_i = a;
        divisor_i  = b;
        step();
        start_i = 1'b0;
        n = 1;
        while (!valid_o && n < 40) begin
            dividend_i = 8'($urandom);
            divisor_i  = 8'($urandom);
            step();
            n++;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_quot"}, quot_o, eq);
        check({tag, "_rem"}, rem_o, er);
        check({tag, "_dz"}, dz_o, edz);
    endtask

    initial begin
        rst_i        = 1'b1;
        clear_i      = 1'b0;
        start_i      = 1'b0;
        dividend_i   = '0;
        divisor_i    = '0;
        w_clear_i    = 1'b0;
        w_start_i    = 1'b0;
        w_dividend_i = '0;
        w_divisor_i  = '0;
        step();
        step();
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_quot", quot_o, 0);
        check("rst_rem", rem_o, 0);
        check("rst_dz", dz_o, 0);
        rst_i = 1'b0;
        step();

        // 100/7 with ready_o low in cycles 1..8
        start_i    = 1'b1;
        dividend_i = 8'd100;
        divisor_i  = 8'd7;
        step();
        start_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("t1_ready_c%0d", c), ready_o, 0);
            check($sformatf("t1_valid_c%0d", c), valid_o, 0);
            step();
        end
        check("t1_valid", valid_o, 1);
        check("t1_ready", ready_o, 1);
        check("t1_quot", quot_o, 14);
        check("t1_rem", rem_o, 2);
        check("t1_dz", dz_o, 0);

        do_op(8'd255, 8'd1, 9, 8'd255, 8'd0, 1'b0, "t2a");
        do_op(8'd3, 8'd200, 9, 8'd0, 8'd3, 1'b0, "t2b");
        do_op(8'd5, 8'd0, FAST ? 1 : 9, 8'd255, 8'd5, 1'b1, "t3");
        do_op(8'd100, 8'd1, 9, 8'd100, 8'd0, 1'b0, "t3_after");

        // start while busy is ignored; start in DONE is accepted
        start_i    = 1'b1;
        dividend_i = 8'd100;
        divisor_i  = 8'd7;
        step();
        start_i = 1'b0;
        for (int c = 1; c < 9; c++) begin
            if (c == 4) begin
                start_i    = 1'b1;
                dividend_i = 8'd9;
                divisor_i  = 8'd3;
            end else begin
                start_i = 1'b0;
            end
            step();
        end
        start_i = 1'b0;
        check("t4_valid", valid_o, 1);
        check("t4_quot", quot_o, 14);
        check("t4_rem", rem_o, 2);
        do_op(8'd9, 8'd3, 9, 8'd3, 8'd0, 1'b0, "t4_done_start");

        // clear mid-operation
        start_i    = 1'b1;
        dividend_i = 8'd200;
        divisor_i  = 8'd9;
        step();
        start_i = 1'b0;
        repeat (4) step();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check("t5c_valid", valid_o, 0);
        check("t5c_ready", ready_o, 1);
        check("t5c_quot", quot_o, 0);
        check("t5c_rem", rem_o, 0);
        check("t5c_dz", dz_o, 0);
        repeat (12) step();
        check("t5c_novalid", valid_o, 0);

        // reset mid-operation, zero divisor so dz is set beforehand
        start_i    = 1'b1;
        dividend_i = 8'd200;
        divisor_i  = 8'd0;
        step();
        start_i = 1'b0;
        repeat (4) step();
        check("t5r_dz_before", dz_o, 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("t5r_valid", valid_o, 0);
        check("t5r_ready", ready_o, 1);
        check("t5r_quot", quot_o, 0);
        check("t5r_rem", rem_o, 0);
        check("t5r_dz", dz_o, 0);
        repeat (12) step();
        check("t5r_novalid", valid_o, 0);

        // random sweep on the 16/5 instance
        for (int k = 0; k < 1000; k++) begin
            logic [15:0] a;
            logic [4:0]  d;
            logic [15:0] eq;
            logic [4:0]  er;
            int          n;
            int          lat;
            a  = 16'($urandom);
            d  = (k % 8 == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            if (d == 0) begin
                eq = 16'hFFFF;
                er = a[4:0];
            end else begin
                eq = a / 16'(d);
                er = 5'(a % 16'(d));
            end
            lat = (FAST && d == 0) ? 1 : 17;
            w_start_i    = 1'b1;
            w_dividend_i = a;
            w_divisor_i  = d;
            step();
            w_start_i = 1'b0;
            n = 1;
            while (!w_valid_o && n < 60) begin
                w_dividend_i = 16'($urandom);
                w_divisor_i  = 5'($urandom);
                step();
                n++;
            end
            check($sformatf("sw%0d_lat", k), n, lat);
            check($sformatf("sw%0d_quot a=%0d d=%0d", k, a, d), w_quot_o, eq);
            check($sformatf("sw%0d_rem a=%0d d=%0d", k, a, d), w_rem_o, er);
            check($sformatf("sw%0d_dz", k), w_dz_o, (d == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
